// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

  // Force a nibble back into the decimal range: anything above 9 reads as 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_NINE) ? BCD_NINE : nib;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade down-counter digit with borrow-in / borrow-out for chaining.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       bin,
  output logic [3:0] q,
  output logic       bout
);

  // A digit only borrows from the next one up when it is at zero and asked to decrement.
  assign bout = (q == BCD_ZERO) & bin;

  // Load has priority; otherwise decrement on borrow-in, wrapping 0 -> 9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= BCD_ZERO;
    end else if (ld) begin
      q <= ld_val;
    end else if (bin) begin
      q <= (q == BCD_ZERO) ? BCD_NINE : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: FSM, preset register, expiry detection
// and optional auto-reload around a chain of decade down-counters.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  input  logic                en,
  output logic [4*DIGITS-1:0] cnt,
  output logic                busy,
  output logic                done
);

  localparam int                CNT_W   = 4 * DIGITS;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t             state_q;
  state_t             state_d;
  logic               done_q;
  logic               done_d;
  logic [CNT_W-1:0]   preset_q;
  logic [CNT_W-1:0]   san_val;
  logic [CNT_W-1:0]   ld_word;
  logic [CNT_W-1:0]   cnt_w;
  logic [DIGITS:0]    borrow;
  logic               is_run;
  logic               expire;
  logic               reload;
  logic               dig_ld;
  logic               unused_top_borrow;

  assign is_run = (state_q == RUN);

  // Expiry is the decrement that would take the count from 1 to 0; load and
  // stop both pre-empt it, so they are masked out here.
  assign expire = is_run & en & ~load & ~stop & (cnt_w == CNT_ONE);
  assign reload = AUTO_RELOAD & expire;

  // Digits take a parallel load either from the (sanitised) input or, on an
  // auto-reload expiry, from the stored preset instead of decrementing to 0.
  assign dig_ld  = load | reload;
  assign ld_word = load ? san_val : preset_q;

  assign borrow[0] = is_run & en & ~stop & ~load;

  // The top digit's borrow-out would mean counting below zero, which the
  // FSM never allows, so it is intentionally left unconsumed.
  assign unused_top_borrow = borrow[DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign san_val[4*gi +: 4] = bcd_clamp(load_val[4*gi +: 4]);

      bcd_down_digit u_digit (
        .clk    (clk),
        .rst    (rst),
        .ld     (dig_ld),
        .ld_val (ld_word[4*gi +: 4]),
        .bin    (borrow[gi]),
        .q      (cnt_w[4*gi +: 4]),
        .bout   (borrow[gi+1])
      );
    end
  endgenerate

  // Preset register: captures the sanitised load value for later reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_q <= '0;
    end else if (load) begin
      preset_q <= san_val;
    end
  end

  // State and done-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next state and done pulse; priority is load > stop > start > en.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = IDLE;
    end else if (stop) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start) begin
        if (cnt_w != '0) begin
          state_d = RUN;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (expire) begin
      done_d = 1'b1;
      if (!AUTO_RELOAD) begin
        state_d = IDLE;
      end
    end
  end

  assign cnt  = cnt_w;
  assign busy = is_run;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Testbench for bcd_down_timer: one stop-at-zero and one auto-reload
// instance share stimulus and are each compared to a decimal-integer model.
module tb_bcd_down_timer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        en;
  logic [15:0] cnt0;
  logic        busy0;
  logic        done0;
  logic [15:0] cnt1;
  logic        busy1;
  logic        done1;

  int unsigned n_pass;
  int unsigned n_total;

  // Model state, index 0 = stop at zero, index 1 = auto-reload.
  int m_cnt  [2];
  int m_pre  [2];
  bit m_busy [2];
  bit m_done [2];

  bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .en(en), .cnt(cnt0), .busy(busy0), .done(done0)
  );

  bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .en(en), .cnt(cnt1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal value of a load word after each nibble is limited to 9.
  function automatic int clamp_dec(input logic [15:0] v);
    int r;
    int w;
    int d;
    r = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * w;
      w = w * 10;
    end
    return r;
  endfunction

  // Decimal integer to packed BCD.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_pre[k]  = 0;
      m_busy[k] = 1'b0;
      m_done[k] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural timer using the currently driven inputs.
  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (load) begin
        m_pre[k]  = clamp_dec(load_val);
        m_cnt[k]  = m_pre[k];
        m_busy[k] = 1'b0;
      end else if (stop) begin
        m_busy[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (start) begin
          if (m_cnt[k] != 0) m_busy[k] = 1'b1;
          else               m_done[k] = 1'b1;
        end
      end else if (en) begin
        if (m_cnt[k] == 1) begin
          m_done[k] = 1'b1;
          if (k == 1) begin
            m_cnt[k] = m_pre[k];
          end else begin
            m_cnt[k]  = 0;
            m_busy[k] = 1'b0;
          end
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("cnt_stop",    32'(cnt0),  32'(to_bcd(m_cnt[0])));
    chk("busy_stop",   32'(busy0), 32'(m_busy[0]));
    chk("done_stop",   32'(done0), 32'(m_done[0]));
    chk("cnt_reload",  32'(cnt1),  32'(to_bcd(m_cnt[1])));
    chk("busy_reload", 32'(busy1), 32'(m_busy[1]));
    chk("done_reload", 32'(done1), 32'(m_done[1]));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic step(input logic l, input logic [15:0] lv, input logic s,
                      input logic sp, input logic e);
    load     = l;
    load_val = lv;
    start    = s;
    stop     = sp;
    en       = e;
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  // Raise reset between clock edges and check that it takes effect at once.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    stop     = 1'b0;
    en       = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Short countdown 3,2,1,0 with en held high.
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("expired_cnt", 32'(cnt0), 32'h0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Multi-digit borrow chain.
    step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("borrow_0999", 32'(cnt0), 32'h0999);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("borrow_0998", 32'(cnt0), 32'h0998);

    // Nibble clamp, then start from zero.
    step(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
    chk("clamp_0095", 32'(cnt0), 32'h0095);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("zero_start_done", 32'(done0), 32'h1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Auto-reload period of 4.
    step(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Gated enable and stop at 2.
    step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'(i % 2 == 0));
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("stop_hold_2", 32'(cnt0), 32'h0002);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a run.
    step(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Load+stop on the expiry cycle, then stop alone on the expiry cycle.
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0007, 1'b0, 1'b1, 1'b1);
    chk("load_beats_expiry", 32'(cnt0), 32'h0007);
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("stop_beats_expiry", 32'(cnt1), 32'h0001);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_ld;
      logic [15:0] r_lv;
      r_ld = ($urandom_range(0, 99) < 6);
      r_lv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 6));
      step(r_ld, r_lv, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 70));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Multi-digit BCD countdown timer built from cascaded decade down-counters. It is the down-counting, borrow-chained counterpart of the team's decade up-counter with carry-out. Software or an FSM loads a decimal preset, starts the timer, and receives a one-cycle done pulse when the count expires. It is used for decimal-display timeouts and for interval generation when auto-reload is enabled.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
AUTO_RELOAD, 0, 1 = on expiry reload the preset and keep running; 0 = stop at zero.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  capture load_val into count and preset registers.
load_val  input  4*DIGITS  BCD preset; digit 0 is the LSB nibble.
start  input  1  begin counting from the current count.
stop  input  1  abort run; count holds.
en  input  1  count-enable strobe; one decrement per cycle with en=1 while running.
cnt  output  4*DIGITS  current BCD count, registered.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse on expiry, registered.

Behaviour:
- Reset (rst=1, async): cnt=0, preset=0, state=IDLE, busy=0, done=0. Reset mid-run aborts the run with no done pulse.
- States: IDLE, RUN. busy = (state==RUN), registered.
- Input priority per cycle: load > stop > start > en.
- load in any state:
  - Next cycle cnt = preset = sanitised load_val; state = IDLE.
  - Sanitising: any nibble > 9 is clamped to 9 (e.g. 0xC -> 9).
- start in IDLE:
  - cnt != 0: state = RUN on the next edge. The first decrement needs en on a later cycle; en in the same cycle as start is ignored.
  - cnt == 0: state stays IDLE; done pulses on the next cycle.
  - start in RUN: ignored.
- stop in RUN: state = IDLE next edge; cnt holds; no done pulse. stop in IDLE has no effect.
- Decrement, in RUN with en=1:
  - Digit i decrements when all lower digits are 0 (borrow-in).
  - A digit at 0 with borrow-in wraps to 9.
  - Latency: one cycle per en.
  - Example: 0100 -> 0099; 1000 -> 0999.
- Expiry, evaluated when RUN, en=1 and cnt == 1:
  - AUTO_RELOAD=0: cnt -> 0, state -> IDLE, done=1 in the cycle cnt first reads 0.
  - AUTO_RELOAD=1: cnt -> preset (not 0), state stays RUN, done=1 in the cycle cnt first reads preset. The period is exactly preset en-cycles.
  - AUTO_RELOAD=1 with preset == 1: every en cycle is an expiry.
- Simultaneous events:
  - load with expiry: load wins, no done pulse.
  - stop with expiry: stop wins, cnt holds at 1, no done pulse.
- en in IDLE: no effect. cnt never leaves the valid BCD range.

Decomposition:
- Package bcd_timer_pkg:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Constants BCD_ZERO=4'd0, BCD_NINE=4'd9.
  - Function bcd_clamp (nibble -> min(nibble, 9)).
- Sub-module bcd_down_digit, instantiated DIGITS times.
  - Inputs: clk, rst, ld, ld_val, bin (borrow-in).
  - Outputs: q, bout (high when q==0 and bin).
  - Chain: bin[0] = RUN & en & ~stop & ~load; bin[i+1] = bout[i].
  - Top level holds the FSM, the preset register, expiry detection and the reload override.

Test Plan:
- Reset, load_val=0x0003, start, en held high -> cnt 3,2,1,0; done=1 exactly in the cycle cnt=0; busy falls the same edge; no further change.
- load 0x1000, start, one en -> cnt=0x0999; further en gives 0x0998. Checks the multi-digit borrow chain.
- load 0x00A5 -> cnt=0x0095 (clamp); load 0x0000 then start -> done pulse next cycle, busy stays 0.
- AUTO_RELOAD=1, load 0x0004, start, en continuous -> done every 4 cycles; cnt sequence 4,3,2,1,4,3,...; busy stays 1.
- Load 0x0005, start, en toggling 1/0 -> cnt decrements only on en cycles; stop asserted at cnt=2 -> holds at 2, busy=0, no done.
- Assert rst mid-run at cnt=0x0042 -> cnt=0, busy=0, done=0 immediately (async). Load+stop on the expiry cycle -> load value taken, no done.
